// File: rtl/reg_file_wb.sv
// Write-back register file: two bypassed combinational read ports, register 0 tied to zero,
// plus registered last-write observation outputs and a saturating committed-write counter.
module reg_file_wb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  RegWrite,
   input  logic [ADDR_WIDTH-1:0] WriteReg,
   input  logic [DATA_WIDTH-1:0] WriteData,
   input  logic [ADDR_WIDTH-1:0] ReadReg1,
   input  logic [ADDR_WIDTH-1:0] ReadReg2,
   output logic [DATA_WIDTH-1:0] ReadData1,
   output logic [DATA_WIDTH-1:0] ReadData2,
   output logic [ADDR_WIDTH-1:0] LastWriteReg,
   output logic [DATA_WIDTH-1:0] LastWriteData,
   output logic [CNT_WIDTH-1:0]  WriteCount
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [ADDR_WIDTH-1:0] last_reg_q;
   logic [DATA_WIDTH-1:0] last_data_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic [CNT_WIDTH-1:0]  cnt_d;
   logic                  commit;

   assign commit = RegWrite && (WriteReg != '0);

   always_comb begin
      cnt_d = cnt_q;
      if (commit && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         last_reg_q  <= '0;
         last_data_q <= '0;
         cnt_q       <= '0;
      end else begin
         if (commit) begin
            regs_q[WriteReg] <= WriteData;
            last_reg_q       <= WriteReg;
            last_data_q      <= WriteData;
         end
         cnt_q <= cnt_d;
      end
   end

   // Same-cycle WB value wins over stored contents so decode never sees a stale operand.
   function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
      logic [DATA_WIDTH-1:0] val;
      val = regs_q[addr];
      if (addr == '0) begin
         val = '0;
      end else if (RegWrite && (WriteReg == addr)) begin
         val = WriteData;
      end
      return val;
   endfunction

   always_comb begin
      ReadData1 = read_port(ReadReg1);
      ReadData2 = read_port(ReadReg2);
   end

   assign LastWriteReg  = last_reg_q;
   assign LastWriteData = last_data_q;
   assign WriteCount    = cnt_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb; expectations are queued as stimulus is applied and
// popped when the corresponding DUT output is sampled.
module tb_reg_file_wb;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          RegWrite;
   logic [AW-1:0] WriteReg;
   logic [DW-1:0] WriteData;
   logic [AW-1:0] ReadReg1;
   logic [AW-1:0] ReadReg2;
   logic [DW-1:0] ReadData1;
   logic [DW-1:0] ReadData2;
   logic [AW-1:0] LastWriteReg;
   logic [DW-1:0] LastWriteData;
   logic [CW-1:0] WriteCount;

   reg_file_wb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .RegWrite     (RegWrite),
      .WriteReg     (WriteReg),
      .WriteData    (WriteData),
      .ReadReg1     (ReadReg1),
      .ReadReg2     (ReadReg2),
      .ReadData1    (ReadData1),
      .ReadData2    (ReadData2),
      .LastWriteReg (LastWriteReg),
      .LastWriteData(LastWriteData),
      .WriteCount   (WriteCount)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;
   int   exp_cnt  = 0;

   task automatic push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic chk(input logic [31:0] obs);
      exp_t e;
      n_assert++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %h required an expectation", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [31:0] sat_cnt(input int c);
      return (c > 15) ? 32'd15 : 32'(c);
   endfunction

   initial begin
      Reset = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
      ReadReg1 = '0; ReadReg2 = '0;
      tick();
      tick();
      Reset = 1'b0;

      // Reset state
      ReadReg1 = 5'd1; ReadReg2 = 5'd31; #1;
      push("rst_rd1_r1", 32'h0);  push("rst_rd2_r31", 32'h0);
      push("rst_lastreg", 32'h0); push("rst_lastdata", 32'h0); push("rst_cnt", 32'h0);
      chk(ReadData1); chk(ReadData2);
      chk({27'b0, LastWriteReg}); chk(LastWriteData); chk({28'b0, WriteCount});
      ReadReg1 = 5'd0; #1;
      push("rst_rd1_r0", 32'h0);
      chk(ReadData1);

      // Plain write to reg 8
      RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEADBEEF;
      tick();
      RegWrite = 1'b0; ReadReg1 = 5'd8; #1;
      exp_cnt = 1;
      push("wr8_rd1", 32'hDEADBEEF); push("wr8_lastreg", 32'd8);
      push("wr8_lastdata", 32'hDEADBEEF); push("wr8_cnt", sat_cnt(exp_cnt));
      chk(ReadData1); chk({27'b0, LastWriteReg}); chk(LastWriteData); chk({28'b0, WriteCount});

      // Write to reg 0 is discarded
      RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h12345678; ReadReg1 = 5'd0; #1;
      push("wr0_byp_rd1", 32'h0);
      chk(ReadData1);
      tick();
      RegWrite = 1'b0; #1;
      push("wr0_rd1", 32'h0); push("wr0_cnt", sat_cnt(exp_cnt));
      push("wr0_lastreg", 32'd8); push("wr0_lastdata", 32'hDEADBEEF);
      chk(ReadData1); chk({28'b0, WriteCount}); chk({27'b0, LastWriteReg}); chk(LastWriteData);

      // Bypass on both ports
      RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h11111111;
      tick();
      exp_cnt++;
      WriteData = 32'h22222222; ReadReg1 = 5'd9; ReadReg2 = 5'd9; #1;
      push("byp_rd1", 32'h22222222); push("byp_rd2", 32'h22222222);
      chk(ReadData1); chk(ReadData2);
      ReadReg2 = 5'd8; #1;
      push("byp_other_rd2", 32'hDEADBEEF);
      chk(ReadData2);
      tick();
      exp_cnt++;
      RegWrite = 1'b0; #1;
      push("byp_after_rd1", 32'h22222222); push("byp_after_cnt", sat_cnt(exp_cnt));
      push("byp_after_lastreg", 32'd9);
      chk(ReadData1); chk({28'b0, WriteCount}); chk({27'b0, LastWriteReg});

      // No bypass without RegWrite
      WriteReg = 5'd8; WriteData = 32'h0BAD0BAD; ReadReg1 = 5'd8; #1;
      push("nowr_rd1", 32'hDEADBEEF);
      chk(ReadData1);
      tick();
      push("nowr_after_rd1", 32'hDEADBEEF); push("nowr_cnt", sat_cnt(exp_cnt));
      chk(ReadData1); chk({28'b0, WriteCount});

      // Reset with simultaneous write: bypass still visible, write lost
      Reset = 1'b1; RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hFFFFFFFF;
      ReadReg1 = 5'd5; ReadReg2 = 5'd9; #1;
      push("rstwr_byp_rd1", 32'hFFFFFFFF);
      chk(ReadData1);
      tick();
      Reset = 1'b0; RegWrite = 1'b0; #1;
      exp_cnt = 0;
      push("rstwr_rd1", 32'h0); push("rstwr_rd2_r9", 32'h0); push("rstwr_cnt", 32'h0);
      push("rstwr_lastreg", 32'h0); push("rstwr_lastdata", 32'h0);
      chk(ReadData1); chk(ReadData2); chk({28'b0, WriteCount});
      chk({27'b0, LastWriteReg}); chk(LastWriteData);

      // Counter saturation
      for (int i = 0; i < 20; i++) begin
         RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'hA0000000 + 32'(i);
         tick();
         exp_cnt++;
         push("sat_cnt", sat_cnt(exp_cnt));
         chk({28'b0, WriteCount});
      end
      RegWrite = 1'b0; ReadReg1 = 5'd3; #1;
      push("sat_rd1", 32'hA0000013); push("sat_lastdata", 32'hA0000013);
      push("sat_final_cnt", 32'd15);
      chk(ReadData1); chk(LastWriteData); chk({28'b0, WriteCount});

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
